// File: rtl/eve_gene_pkg.sv
// -----------------------------------------------------------------------------
// eve_gene_pkg
// Shared definitions for the NEAT-style gene stream crossover engine:
// gene field offset/width helpers, gene type constants and the crossover
// FSM state encoding.
// Gene layout, MSB..LSB: {id, type, rsvd, src, dst, attr[LANES-1..0]}
// -----------------------------------------------------------------------------
package eve_gene_pkg;

   localparam logic GENE_NODE = 1'b0;
   localparam logic GENE_CONN = 1'b1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MERGE   = 3'd1,
      DRAIN_A = 3'd2,
      DRAIN_B = 3'd3,
      FLUSH   = 3'd4
   } xover_state_e;

   function automatic int unsigned gene_width(input int unsigned id_w, input int unsigned rsv_w,
                                              input int unsigned key_w, input int unsigned lanes,
                                              input int unsigned lane_w);
      return id_w + 32'd1 + rsv_w + 32'd2 * key_w + lanes * lane_w;
   endfunction

   function automatic int unsigned dst_lsb(input int unsigned lanes, input int unsigned lane_w);
      return lanes * lane_w;
   endfunction

   function automatic int unsigned src_lsb(input int unsigned key_w, input int unsigned lanes,
                                           input int unsigned lane_w);
      return dst_lsb(lanes, lane_w) + key_w;
   endfunction

   function automatic int unsigned type_bit(input int unsigned rsv_w, input int unsigned key_w,
                                            input int unsigned lanes, input int unsigned lane_w);
      return src_lsb(key_w, lanes, lane_w) + key_w + rsv_w;
   endfunction

   function automatic int unsigned id_lsb(input int unsigned rsv_w, input int unsigned key_w,
                                          input int unsigned lanes, input int unsigned lane_w);
      return type_bit(rsv_w, key_w, lanes, lane_w) + 32'd1;
   endfunction

endpackage

// File: rtl/eve_gene_key_cmp.sv
// -----------------------------------------------------------------------------
// eve_gene_key_cmp
// Combinational gene key comparator. Nodes sort before connections; nodes
// compare src only, connections compare src then dst (unsigned).
// Ports: a_type_i/a_src_i/a_dst_i  key of gene A
//        b_type_i/b_src_i/b_dst_i  key of gene B
//        lt_o/eq_o/gt_o            A<B, A==B, A>B (exactly one high)
// -----------------------------------------------------------------------------
module eve_gene_key_cmp
   import eve_gene_pkg::*;
#(
   parameter int unsigned KEY_W = 8
) (
   input  logic             a_type_i,
   input  logic [KEY_W-1:0] a_src_i,
   input  logic [KEY_W-1:0] a_dst_i,
   input  logic             b_type_i,
   input  logic [KEY_W-1:0] b_src_i,
   input  logic [KEY_W-1:0] b_dst_i,
   output logic             lt_o,
   output logic             eq_o,
   output logic             gt_o
);

   // Ordered key comparison: type, then src, then dst for connections only
   always_comb begin
      lt_o = 1'b0;
      eq_o = 1'b0;
      gt_o = 1'b0;
      if (a_type_i != b_type_i) begin
         lt_o = (a_type_i == GENE_NODE);
         gt_o = (a_type_i != GENE_NODE);
      end else if (a_src_i != b_src_i) begin
         lt_o = (a_src_i < b_src_i);
         gt_o = (a_src_i > b_src_i);
      end else if ((a_type_i == GENE_CONN) && (a_dst_i != b_dst_i)) begin
         lt_o = (a_dst_i < b_dst_i);
         gt_o = (a_dst_i > b_dst_i);
      end else begin
         eq_o = 1'b1;
      end
   end

endmodule

// File: rtl/eve_stream_crossover.sv
// -----------------------------------------------------------------------------
// eve_stream_crossover
// Merges two key-sorted parent gene streams (A = fitter, B = other) into one
// child gene stream. Matching genes mix attribute lanes from per-lane random
// slices; disjoint/excess genes come from A, and from B only when keep_b.
// Ports: clk, rst (sync, active-high)
//        start_i, cfg_child_id_i, cfg_thresh_i, cfg_keep_b_i  run control/config
//        rand_in_i                  per-lane random slices
//        a_valid_i/a_ready_o/a_data_i/a_last_i  parent A stream
//        b_valid_i/b_ready_o/b_data_i/b_last_i  parent B stream
//        o_valid_o/o_ready_i/o_data_o           child stream (registered)
//        busy_o, done_o, gene_count_o            run status
// -----------------------------------------------------------------------------
module eve_stream_crossover
   import eve_gene_pkg::*;
#(
   parameter int unsigned ID_W   = 8,
   parameter int unsigned KEY_W  = 8,
   parameter int unsigned RSV_W  = 7,
   parameter int unsigned LANES  = 4,
   parameter int unsigned LANE_W = 8,
   parameter int unsigned RAND_W = 32,
   parameter int unsigned CNT_W  = 16,
   localparam int unsigned GENE_W = gene_width(ID_W, RSV_W, KEY_W, LANES, LANE_W)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [ID_W-1:0]         cfg_child_id_i,
   input  logic [RAND_W-1:0]       cfg_thresh_i,
   input  logic                    cfg_keep_b_i,
   input  logic [LANES*RAND_W-1:0] rand_in_i,
   input  logic                    a_valid_i,
   output logic                    a_ready_o,
   input  logic [GENE_W-1:0]       a_data_i,
   input  logic                    a_last_i,
   input  logic                    b_valid_i,
   output logic                    b_ready_o,
   input  logic [GENE_W-1:0]       b_data_i,
   input  logic                    b_last_i,
   output logic                    o_valid_o,
   input  logic                    o_ready_i,
   output logic [GENE_W-1:0]       o_data_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [CNT_W-1:0]        gene_count_o
);

   localparam int unsigned ATTR_W   = LANES * LANE_W;
   localparam int unsigned DST_LSB  = dst_lsb(LANES, LANE_W);
   localparam int unsigned SRC_LSB  = src_lsb(KEY_W, LANES, LANE_W);
   localparam int unsigned TYPE_BIT = type_bit(RSV_W, KEY_W, LANES, LANE_W);
   localparam int unsigned ID_LSB   = id_lsb(RSV_W, KEY_W, LANES, LANE_W);

   xover_state_e        state_q, state_d;
   logic [ID_W-1:0]     cfg_child_id_q, cfg_child_id_d;
   logic [RAND_W-1:0]   cfg_thresh_q, cfg_thresh_d;
   logic                cfg_keep_b_q, cfg_keep_b_d;
   logic                o_valid_q, o_valid_d;
   logic [GENE_W-1:0]   o_data_q, o_data_d;
   logic [CNT_W-1:0]    gene_count_q, gene_count_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                adv_s, lt_s, eq_s, gt_s;
   logic                a_ready_s, b_ready_s, load_s, start_acc_s;
   logic [GENE_W-1:0]   load_data_s, a_out_s, b_out_s, m_out_s;
   logic [ATTR_W-1:0]   mix_attr_s;
   logic                unused_s;

   eve_gene_key_cmp #(.KEY_W(KEY_W)) u_key_cmp (
      .a_type_i (a_data_i[TYPE_BIT]),
      .a_src_i  (a_data_i[SRC_LSB +: KEY_W]),
      .a_dst_i  (a_data_i[DST_LSB +: KEY_W]),
      .b_type_i (b_data_i[TYPE_BIT]),
      .b_src_i  (b_data_i[SRC_LSB +: KEY_W]),
      .b_dst_i  (b_data_i[DST_LSB +: KEY_W]),
      .lt_o     (lt_s),
      .eq_o     (eq_s),
      .gt_o     (gt_s)
   );

   // Parent id fields are always overwritten; gt is implied by !lt && !eq
   assign unused_s = ^{a_data_i[GENE_W-1:ID_LSB], b_data_i[GENE_W-1:ID_LSB], gt_s};

   // Output register can take a new gene when empty or being drained this cycle
   assign adv_s = !o_valid_q || o_ready_i;

   // Lane i goes to B only when its random slice is strictly above the threshold
   for (genvar l = 0; l < LANES; l++) begin : g_lane_mux
      assign mix_attr_s[l*LANE_W +: LANE_W] =
         (rand_in_i[l*RAND_W +: RAND_W] > cfg_thresh_q) ? b_data_i[l*LANE_W +: LANE_W]
                                                        : a_data_i[l*LANE_W +: LANE_W];
   end

   assign a_out_s = {cfg_child_id_q, a_data_i[ID_LSB-1:0]};
   assign b_out_s = {cfg_child_id_q, b_data_i[ID_LSB-1:0]};
   assign m_out_s = {cfg_child_id_q, a_data_i[ID_LSB-1:ATTR_W], mix_attr_s};

   // Next-state, parent handshakes and output-register load selection
   always_comb begin
      state_d     = state_q;
      a_ready_s   = 1'b0;
      b_ready_s   = 1'b0;
      load_s      = 1'b0;
      load_data_s = a_out_s;
      busy_d      = busy_q;
      done_d      = 1'b0;
      start_acc_s = 1'b0;
      case (state_q)
         IDLE: begin
            // busy_q is still high in the done cycle, so a start there is ignored
            if (start_i && !busy_q) begin
               state_d     = MERGE;
               busy_d      = 1'b1;
               start_acc_s = 1'b1;
            end else begin
               busy_d = 1'b0;
            end
         end
         MERGE: begin
            if (a_valid_i && b_valid_i && adv_s) begin
               if (eq_s) begin
                  a_ready_s   = 1'b1;
                  b_ready_s   = 1'b1;
                  load_s      = 1'b1;
                  load_data_s = m_out_s;
               end else if (lt_s) begin
                  a_ready_s   = 1'b1;
                  load_s      = 1'b1;
                  load_data_s = a_out_s;
               end else begin
                  b_ready_s   = 1'b1;
                  load_s      = cfg_keep_b_q;
                  load_data_s = b_out_s;
               end
               if (a_ready_s && a_last_i && b_ready_s && b_last_i) begin
                  state_d = FLUSH;
               end else if (a_ready_s && a_last_i) begin
                  state_d = DRAIN_B;
               end else if (b_ready_s && b_last_i) begin
                  state_d = DRAIN_A;
               end else begin
                  state_d = MERGE;
               end
            end else begin
               state_d = MERGE;
            end
         end
         DRAIN_A: begin
            if (a_valid_i && adv_s) begin
               a_ready_s   = 1'b1;
               load_s      = 1'b1;
               load_data_s = a_out_s;
               state_d     = a_last_i ? FLUSH : DRAIN_A;
            end else begin
               state_d = DRAIN_A;
            end
         end
         DRAIN_B: begin
            if (b_valid_i && adv_s) begin
               b_ready_s   = 1'b1;
               load_s      = cfg_keep_b_q;
               load_data_s = b_out_s;
               state_d     = b_last_i ? FLUSH : DRAIN_B;
            end else begin
               state_d = DRAIN_B;
            end
         end
         FLUSH: begin
            // Last gene must have left the output register before done
            if (adv_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = FLUSH;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Config latch, output register and saturating gene counter next-state
   always_comb begin
      cfg_child_id_d = cfg_child_id_q;
      cfg_thresh_d   = cfg_thresh_q;
      cfg_keep_b_d   = cfg_keep_b_q;
      o_valid_d      = o_valid_q;
      o_data_d       = o_data_q;
      gene_count_d   = gene_count_q;
      if (start_acc_s) begin
         cfg_child_id_d = cfg_child_id_i;
         cfg_thresh_d   = cfg_thresh_i;
         cfg_keep_b_d   = cfg_keep_b_i;
      end else begin
         cfg_child_id_d = cfg_child_id_q;
      end
      if (load_s) begin
         o_valid_d = 1'b1;
         o_data_d  = load_data_s;
      end else if (o_ready_i) begin
         o_valid_d = 1'b0;
      end else begin
         o_valid_d = o_valid_q;
      end
      if (start_acc_s) begin
         gene_count_d = {CNT_W{1'b0}};
      end else if (load_s && (gene_count_q != {CNT_W{1'b1}})) begin
         gene_count_d = gene_count_q + CNT_W'(1);
      end else begin
         gene_count_d = gene_count_q;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cfg_child_id_q <= {ID_W{1'b0}};
         cfg_thresh_q   <= {RAND_W{1'b0}};
         cfg_keep_b_q   <= 1'b0;
         o_valid_q      <= 1'b0;
         o_data_q       <= {GENE_W{1'b0}};
         gene_count_q   <= {CNT_W{1'b0}};
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cfg_child_id_q <= cfg_child_id_d;
         cfg_thresh_q   <= cfg_thresh_d;
         cfg_keep_b_q   <= cfg_keep_b_d;
         o_valid_q      <= o_valid_d;
         o_data_q       <= o_data_d;
         gene_count_q   <= gene_count_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign a_ready_o    = a_ready_s;
   assign b_ready_o    = b_ready_s;
   assign o_valid_o    = o_valid_q;
   assign o_data_o     = o_data_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign gene_count_o = gene_count_q;

endmodule

// File: tb/tb_eve_stream_crossover.sv
// -----------------------------------------------------------------------------
// tb_eve_stream_crossover
// Directed and randomized bench for eve_stream_crossover. Expected child
// streams come from a queue-based merge model using integer key ranks.
// -----------------------------------------------------------------------------
module tb_eve_stream_crossover;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [7:0]    cfg_child_id_i;
   logic [31:0]   cfg_thresh_i;
   logic          cfg_keep_b_i;
   logic [127:0]  rand_in_i;
   logic          a_valid_i, a_ready_o, a_last_i;
   logic [63:0]   a_data_i;
   logic          b_valid_i, b_ready_o, b_last_i;
   logic [63:0]   b_data_i;
   logic          o_valid_o, o_ready_i;
   logic [63:0]   o_data_o;
   logic          busy_o, done_o;
   logic [15:0]   gene_count_o;

   int            ntests = 0;
   int            nfail  = 0;
   logic [63:0]   ga[$], gb[$], exp_q[$], got_q[$];
   logic [127:0]  rtab[$];

   eve_stream_crossover dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .cfg_child_id_i(cfg_child_id_i), .cfg_thresh_i(cfg_thresh_i), .cfg_keep_b_i(cfg_keep_b_i),
      .rand_in_i(rand_in_i),
      .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i), .a_last_i(a_last_i),
      .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i), .b_last_i(b_last_i),
      .o_valid_o(o_valid_o), .o_ready_i(o_ready_i), .o_data_o(o_data_o),
      .busy_o(busy_o), .done_o(done_o), .gene_count_o(gene_count_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      ntests++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // gene = {id, type, rsvd, src, dst, attr}; id and rsvd are random junk
   function automatic logic [63:0] mkg(input logic t, input logic [7:0] s, input logic [7:0] d,
                                       input logic [31:0] at);
      return {8'($urandom), t, 7'($urandom), s, d, at};
   endfunction

   function automatic logic [63:0] nd(input logic [7:0] s);
      return mkg(1'b0, s, 8'($urandom), 32'($urandom));
   endfunction

   function automatic logic [63:0] cn(input logic [7:0] s, input logic [7:0] d);
      return mkg(1'b1, s, d, 32'($urandom));
   endfunction

   // Total order as one integer: every node ranks below every connection
   function automatic int unsigned rank(input logic [63:0] g);
      if (g[55]) return 32'd65536 + {16'd0, g[47:40], g[39:32]};
      else       return {24'd0, g[47:40]};
   endfunction

   function automatic logic [63:0] mix(input logic [63:0] a, input logic [63:0] b,
                                       input logic [127:0] r, input logic [31:0] th,
                                       input logic [7:0] id);
      logic [31:0] at;
      for (int l = 0; l < 4; l++)
         at[l*8 +: 8] = (r[l*32 +: 32] > th) ? b[l*8 +: 8] : a[l*8 +: 8];
      return {id, a[55:32], at};
   endfunction

   task automatic build_exp(input logic [7:0] id, input logic [31:0] th, input logic kb);
      int i, j;
      i = 0;
      j = 0;
      exp_q.delete();
      while (i < ga.size() && j < gb.size()) begin
         if (rank(ga[i]) == rank(gb[j])) begin
            exp_q.push_back(mix(ga[i], gb[j], rtab[i], th, id));
            i++;
            j++;
         end else if (rank(ga[i]) < rank(gb[j])) begin
            exp_q.push_back({id, ga[i][55:0]});
            i++;
         end else begin
            if (kb) exp_q.push_back({id, gb[j][55:0]});
            j++;
         end
      end
      while (i < ga.size()) begin
         exp_q.push_back({id, ga[i][55:0]});
         i++;
      end
      while (j < gb.size()) begin
         if (kb) exp_q.push_back({id, gb[j][55:0]});
         j++;
      end
   endtask

   task automatic fill_rtab();
      rtab.delete();
      foreach (ga[k]) rtab.push_back({$urandom, $urandom, $urandom, $urandom});
   endtask

   // Random ascending parents over nodes 0..11 then conns (0..3,0..3)
   task automatic gen_rand();
      int r;
      ga.delete();
      gb.delete();
      for (int s = 0; s < 12; s++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) ga.push_back(nd(8'(s)));
         if (r <= 2 || r == 5 || r == 6) gb.push_back(nd(8'(s)));
      end
      for (int s = 0; s < 4; s++) begin
         for (int d = 0; d < 4; d++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) ga.push_back(cn(8'(s), 8'(d)));
            if (r <= 2 || r == 5 || r == 6) gb.push_back(cn(8'(s), 8'(d)));
         end
      end
      if (ga.size() == 0) ga.push_back(cn(8'd9, 8'd9));
      if (gb.size() == 0) gb.push_back(cn(8'd9, 8'd10));
   endtask

   task automatic run_case(input logic [7:0] id, input logic [31:0] th, input logic kb,
                           input int stall_at, input logic rnd);
      int ai, bi, extra;
      logic a_fire, b_fire, held, finished;
      logic [63:0] held_d;
      build_exp(id, th, kb);
      got_q.delete();
      ai = 0; bi = 0; extra = 0;
      a_fire = 1'b0; b_fire = 1'b0; held = 1'b0; finished = 1'b0; held_d = 64'd0;
      a_valid_i = 1'b0;
      b_valid_i = 1'b0;
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         @(negedge clk);
         start_i        = (cyc == 0);
         cfg_child_id_i = (cyc == 0) ? id : 8'($urandom);
         cfg_thresh_i   = (cyc == 0) ? th : 32'($urandom);
         cfg_keep_b_i   = (cyc == 0) ? kb : 1'($urandom);
         if (a_fire || !a_valid_i)
            a_valid_i = (ai < ga.size()) && (!rnd || $urandom_range(0, 3) != 0);
         if (b_fire || !b_valid_i)
            b_valid_i = (bi < gb.size()) && (!rnd || $urandom_range(0, 3) != 0);
         if (ai < ga.size()) begin
            a_data_i  = ga[ai];
            rand_in_i = rtab[ai];
         end else begin
            a_data_i  = 64'd0;
            rand_in_i = {$urandom, $urandom, $urandom, $urandom};
         end
         if (bi < gb.size()) b_data_i = gb[bi];
         else                b_data_i = 64'd0;
         a_last_i  = (ai == ga.size() - 1);
         b_last_i  = (bi == gb.size() - 1);
         o_ready_i = (cyc >= stall_at && cyc < stall_at + 5) ? 1'b0
                   : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         #1;
         if (held) begin
            chk("hold_data", o_data_o, held_d);
            chk("hold_valid", 64'(o_valid_o), 64'd1);
         end
         if (o_valid_o && !o_ready_i) chk("stall_ready", 64'({a_ready_o, b_ready_o}), 64'd0);
         held   = o_valid_o && !o_ready_i;
         held_d = o_data_o;
         a_fire = a_valid_i && a_ready_o;
         b_fire = b_valid_i && b_ready_o;
         if (a_fire) ai++;
         if (b_fire) bi++;
         if (o_valid_o && o_ready_i) got_q.push_back(o_data_o);
         if (done_o) begin
            finished = 1'b1;
            start_i  = 1'b1;   // start coinciding with done must be ignored
         end
      end
      chk("done_seen", 64'(finished), 64'd1);
      chk("gene_n", 64'(got_q.size()), 64'(exp_q.size()));
      foreach (exp_q[k])
         chk($sformatf("gene%0d", k), (k < got_q.size()) ? got_q[k] : 64'hx, exp_q[k]);
      chk("gene_count", 64'(gene_count_o), 64'(exp_q.size()));
      @(negedge clk);
      start_i   = 1'b0;
      a_valid_i = 1'b0;
      b_valid_i = 1'b0;
      o_ready_i = 1'b1;
      #1;
      chk("busy_after", 64'(busy_o), 64'd0);
      for (int c = 0; c < 4; c++) begin
         if (done_o) extra++;
         @(negedge clk);
         #1;
      end
      chk("done_once", 64'(extra), 64'd0);
      chk("count_held", 64'(gene_count_o), 64'(exp_q.size()));
   endtask

   task automatic abort_run();
      @(negedge clk);
      start_i = 1'b1; cfg_child_id_i = 8'h33; cfg_thresh_i = 32'h0; cfg_keep_b_i = 1'b1;
      a_valid_i = 1'b1; a_data_i = ga[0]; a_last_i = 1'b0; rand_in_i = rtab[0];
      b_valid_i = 1'b1; b_data_i = gb[0]; b_last_i = 1'b0; o_ready_i = 1'b0;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      #1;
      chk("pre_rst_valid", 64'(o_valid_o), 64'd1);
      chk("pre_rst_busy", 64'(busy_o), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_o_valid", 64'(o_valid_o), 64'd0);
      chk("rst_ready", 64'({a_ready_o, b_ready_o}), 64'd0);
      chk("rst_busy_done", 64'({busy_o, done_o}), 64'd0);
      chk("rst_o_data", o_data_o, 64'd0);
      chk("rst_count", 64'(gene_count_o), 64'd0);
      @(negedge clk);
      rst = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0; o_ready_i = 1'b1;
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; cfg_child_id_i = 8'd0; cfg_thresh_i = 32'd0;
      cfg_keep_b_i = 1'b0; rand_in_i = 128'd0; a_valid_i = 1'b0; a_data_i = 64'd0;
      a_last_i = 1'b0; b_valid_i = 1'b0; b_data_i = 64'd0; b_last_i = 1'b0; o_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_o_valid", 64'(o_valid_o), 64'd0);
      chk("reset_ready", 64'({a_ready_o, b_ready_o}), 64'd0);
      chk("reset_busy_done", 64'({busy_o, done_o}), 64'd0);
      chk("reset_o_data", o_data_o, 64'd0);
      chk("reset_count", 64'(gene_count_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Identical parents, threshold all-ones: everything from A
      ga.delete(); gb.delete();
      ga.push_back(nd(8'd1)); ga.push_back(nd(8'd2)); ga.push_back(cn(8'd1, 8'd3));
      gb.push_back(nd(8'd1)); gb.push_back(nd(8'd2)); gb.push_back(cn(8'd1, 8'd3));
      fill_rtab();
      run_case(8'h5A, 32'hFFFF_FFFF, 1'b0, 1000, 1'b0);
      chk("c1_count", 64'(gene_count_o), 64'd3);
      for (int k = 0; k < 3; k++)
         chk("c1_attr_a", (k < got_q.size()) ? {32'd0, got_q[k][31:0]} : 64'hx, {32'd0, ga[k][31:0]});

      // Per-lane mix: lanes 3,1 above threshold, lane 2 equal, lane 0 below
      ga.delete(); gb.delete(); rtab.delete();
      ga.push_back(mkg(1'b0, 8'd7, 8'd3, 32'h1122_3344));
      gb.push_back(mkg(1'b0, 8'd7, 8'd9, 32'hAABB_CCDD));
      rtab.push_back({32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0001, 32'h0000_0000});
      run_case(8'hC3, 32'h8000_0000, 1'b0, 1000, 1'b0);
      chk("lane_mix", (got_q.size() > 0) ? {32'd0, got_q[0][31:0]} : 64'hx, 64'h0000_0000_AA22_CC44);

      // Disjoint/excess B genes dropped, then kept
      ga.delete(); gb.delete();
      ga.push_back(nd(8'd1)); ga.push_back(nd(8'd3));
      gb.push_back(nd(8'd1)); gb.push_back(nd(8'd2)); gb.push_back(nd(8'd4));
      gb.push_back(cn(8'd1, 8'd2));
      fill_rtab();
      run_case(8'h11, 32'h4000_0000, 1'b0, 1000, 1'b0);
      chk("keep0_count", 64'(gene_count_o), 64'd2);
      run_case(8'h12, 32'h4000_0000, 1'b1, 1000, 1'b0);
      chk("keep1_count", 64'(gene_count_o), 64'd5);

      // Output stall of 5 cycles mid-run
      run_case(8'h13, 32'h4000_0000, 1'b1, 3, 1'b0);

      // Node before conn with same src; conn (1,2) before (1,4)
      ga.delete(); gb.delete();
      ga.push_back(nd(8'd1)); ga.push_back(cn(8'd1, 8'd4));
      gb.push_back(cn(8'd1, 8'd2));
      fill_rtab();
      run_case(8'h21, 32'h0, 1'b1, 1000, 1'b0);
      chk("order_node_first", (got_q.size() > 0) ? 64'(got_q[0][55]) : 64'hx, 64'd0);
      chk("order_conn_dst", (got_q.size() > 1) ? 64'(got_q[1][39:32]) : 64'hx, 64'd2);

      // Reset mid-merge, then a clean run
      ga.delete(); gb.delete();
      ga.push_back(nd(8'd1)); ga.push_back(nd(8'd3));
      gb.push_back(nd(8'd1)); gb.push_back(nd(8'd2));
      fill_rtab();
      abort_run();
      run_case(8'h44, 32'h8000_0000, 1'b1, 1000, 1'b0);

      // Randomized parents, backpressure and gaps
      for (int r = 0; r < 8; r++) begin
         gen_rand();
         fill_rtab();
         run_case(8'($urandom), (r % 4 == 3) ? 32'hFFFF_FFFF : 32'($urandom), 1'($urandom),
                  $urandom_range(2, 30), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
